// File: rtl/umem_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, mux select codes and the BRAM request.
package umem_pkg;

  localparam int unsigned MEM_LAT     = 1;
  localparam int unsigned MEM_WADDR_W = 30;
  localparam int unsigned MEM_DATA_W  = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SPLIT, ARB_PROG} arb_state_t;

  typedef enum logic [1:0] {SEL_NONE, SEL_DATA, SEL_FETCH, SEL_PROG} mem_sel_t;

  typedef struct packed {
    logic                   en;
    logic [3:0]             we;
    logic [MEM_WADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0]  din;
  } mem_req_t;

endpackage

// File: rtl/umem_req_mux.sv
// Combinational choice of which requester drives the BRAM port this cycle.
module umem_req_mux
  import umem_pkg::*;
(
  input  mem_sel_t              sel,
  input  logic                  prog_we,
  input  logic [31:0]           prog_addr,
  input  logic [MEM_DATA_W-1:0] prog_din,
  input  logic [31:0]           i_addr,
  input  logic [3:0]            d_en,
  input  logic                  d_wea,
  input  logic [31:0]           d_addr,
  input  logic [MEM_DATA_W-1:0] d_din,
  output mem_req_t              req
);

  // Byte offsets never reach the word-organised BRAM.
  logic unused_byte_off;
  assign unused_byte_off = ^{prog_addr[1:0], i_addr[1:0], d_addr[1:0]};

  always_comb begin
    req = '0;
    unique case (sel)
      SEL_PROG: begin
        req.en   = 1'b1;
        req.we   = prog_we ? 4'hF : 4'h0;
        req.addr = prog_addr[31:2];
        req.din  = prog_din;
      end
      SEL_DATA: begin
        req.en   = 1'b1;
        req.we   = d_wea ? d_en : 4'h0;
        req.addr = d_addr[31:2];
        req.din  = d_din;
      end
      SEL_FETCH: begin
        req.en   = 1'b1;
        req.addr = i_addr[31:2];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/umem_arbiter.sv
// Single-port BRAM arbiter: splits fetch/data conflicts with a one-cycle hold and hands the
// memory to the UART programmer while prog_ena is high.
module umem_arbiter
  import umem_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              prog_ena,
  input  logic              prog_we,
  input  logic [31:0]       prog_addr,
  input  logic [DATA_W-1:0] prog_din,
  input  logic              i_en,
  input  logic [31:0]       i_addr,
  output logic [DATA_W-1:0] i_dout,
  input  logic [3:0]        d_en,
  input  logic              d_wea,
  input  logic              d_rea,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_din,
  output logic [DATA_W-1:0] d_dout,
  output logic              mem_hold,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  input  logic [DATA_W-1:0] m_dout,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // The SPLIT capture relies on a single-cycle BRAM and the request struct's data width.
  if (MEM_LAT != 1 || DATA_W != MEM_DATA_W || ADDR_W >= MEM_WADDR_W) begin : g_param_check
    $error("umem_arbiter: unsupported parameter combination");
  end

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] d_buf_q;
  logic              use_dbuf_q;
  logic [CNT_W-1:0]  conflict_cnt_q;

  mem_sel_t sel;
  mem_req_t req;
  logic     d_req, split_done, conflict;

  assign d_req = d_wea | d_rea;

  always_comb begin
    sel        = SEL_NONE;
    mem_hold   = 1'b0;
    state_d    = state_q;
    split_done = 1'b0;
    conflict   = 1'b0;
    if (prog_ena) begin
      sel      = SEL_PROG;
      mem_hold = 1'b1;
      state_d  = ARB_PROG;
    end else if (state_q == ARB_SPLIT) begin
      // Data was issued last cycle; its result is on m_dout now, fetch goes out.
      sel        = SEL_FETCH;
      state_d    = ARB_IDLE;
      split_done = 1'b1;
    end else begin
      state_d = ARB_IDLE;
      if (d_req) begin
        sel = SEL_DATA;
        if (i_en) begin
          mem_hold = 1'b1;
          conflict = 1'b1;
          state_d  = ARB_SPLIT;
        end
      end else if (i_en) begin
        sel = SEL_FETCH;
      end
    end
    if (Rst) begin
      sel      = SEL_NONE;
      mem_hold = 1'b0;
    end
  end

  umem_req_mux u_req_mux (
    .sel       (sel),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_din  (prog_din),
    .i_addr    (i_addr),
    .d_en      (d_en),
    .d_wea     (d_wea),
    .d_addr    (d_addr),
    .d_din     (d_din),
    .req       (req)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q        <= ARB_IDLE;
      use_dbuf_q     <= 1'b0;
      d_buf_q        <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      use_dbuf_q <= split_done;
      if (split_done) begin
        d_buf_q <= m_dout;
      end
      if (conflict && conflict_cnt_q != '1) begin
        conflict_cnt_q <= conflict_cnt_q + CNT_W'(1);
      end
    end
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^req.addr[MEM_WADDR_W-1:ADDR_W];

  assign m_en         = req.en;
  assign m_we         = req.we;
  assign m_addr       = req.addr[ADDR_W-1:0];
  assign m_din        = req.din;
  assign i_dout       = m_dout;
  assign d_dout       = use_dbuf_q ? d_buf_q : m_dout;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_umem_arbiter.sv
// Randomised bench for umem_arbiter: a transaction-level memory model predicts hold cycles,
// port addresses, returned data, write pulses and the saturating conflict count.
module tb_umem_arbiter;

  localparam int unsigned AW     = 12;
  localparam int unsigned DW     = 32;
  localparam int unsigned CW     = 4;
  localparam int unsigned CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          Rst;
  logic          prog_ena, prog_we;
  logic [31:0]   prog_addr, prog_din;
  logic          i_en;
  logic [31:0]   i_addr, i_dout;
  logic [3:0]    d_en;
  logic          d_wea, d_rea;
  logic [31:0]   d_addr, d_din, d_dout;
  logic          mem_hold, m_en;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_dout;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  umem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .Rst          (Rst),
    .prog_ena     (prog_ena),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_din     (prog_din),
    .i_en         (i_en),
    .i_addr       (i_addr),
    .i_dout       (i_dout),
    .d_en         (d_en),
    .d_wea        (d_wea),
    .d_rea        (d_rea),
    .d_addr       (d_addr),
    .d_din        (d_din),
    .d_dout       (d_dout),
    .mem_hold     (mem_hold),
    .m_en         (m_en),
    .m_we         (m_we),
    .m_addr       (m_addr),
    .m_din        (m_din),
    .m_dout       (m_dout),
    .conflict_cnt (conflict_cnt)
  );

  // BRAM: read-first, one-cycle latency, output holds while disabled.
  logic [31:0] bram [4096];
  int          wr_pulses = 0;
  always @(posedge clk) begin
    if (m_en) begin
      m_dout <= bram[m_addr];
      for (int b = 0; b < 4; b++) if (m_we[b]) bram[m_addr][8*b +: 8] <= m_din[8*b +: 8];
      if (m_we != 4'h0) wr_pulses <= wr_pulses + 1;
    end
  end

  // Reference view of memory contents and expected counters.
  logic [31:0] gmem [4096];
  int unsigned exp_cnt = 0;
  int          exp_pulses = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr(input int unsigned w);
    return ($urandom() & 32'hFFFF_C000) | (w << 2) | ($urandom() & 32'h3);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned c);
    return (c >= CNTMAX) ? CNTMAX : c + 1;
  endfunction

  task automatic idle_inputs();
    prog_ena = 0; prog_we = 0; prog_addr = 0; prog_din = 0;
    i_en = 0; i_addr = 0; d_en = 0; d_wea = 0; d_rea = 0; d_addr = 0; d_din = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input int unsigned w, input logic [31:0] val);
    idle_inputs();
    prog_ena = 1; prog_we = 1; prog_addr = rand_addr(w); prog_din = val;
    gmem[w] = val;
    exp_pulses++;
    @(negedge clk);
    check("prog_hold", mem_hold, 1);
    check("prog_we", m_we, 4'hF);
    check("prog_addr", m_addr, w);
    next_cycle();
  endtask

  // dk: 0 none, 1 load, 2 store
  task automatic run_txn(input bit f, input int dk, input int unsigned iw, input int unsigned dw,
                         input logic [3:0] be, input logic [31:0] din);
    logic [31:0] exp_d, exp_i;
    bit          confl;
    idle_inputs();
    confl  = f && (dk != 0);
    i_en   = f;     i_addr = rand_addr(iw);
    d_rea  = (dk == 1); d_wea = (dk == 2);
    d_en   = (dk == 2) ? be : 4'hF;
    d_addr = rand_addr(dw); d_din = din;
    exp_d  = gmem[dw];
    if (dk == 2) begin
      gmem[dw] = merge(gmem[dw], din, be);
      exp_pulses++;
    end
    exp_i = gmem[iw];
    if (confl) exp_cnt = sat_inc(exp_cnt);
    @(negedge clk);
    check("hold", mem_hold, confl);
    if (dk != 0) check("addr_d", m_addr, dw);
    else if (f) check("addr_i", m_addr, iw);
    else check("en_idle", m_en, 0);
    if (dk == 2) check("we_d", m_we, be);
    next_cycle();
    if (confl) begin
      @(negedge clk);
      check("hold_rel", mem_hold, 0);
      check("en_split", m_en, 1);
      check("addr_split", m_addr, iw);
      check("we_split", m_we, 0);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    if (dk == 1) check("d_dout", d_dout, exp_d);
    if (f) check("i_dout", i_dout, exp_i);
    check("cnt", conflict_cnt, exp_cnt);
    check("pulses", wr_pulses, exp_pulses);
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) gmem[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;

    // Reset forces the BRAM port quiet even with every requester active.
    Rst = 1;
    idle_inputs();
    prog_ena = 1; prog_we = 1; prog_addr = 32'h44; prog_din = 32'hFFFF_FFFF;
    i_en = 1; d_wea = 1; d_en = 4'hF; d_addr = 32'h48; d_din = 32'h1234_5678;
    @(negedge clk);
    check("rst_hold", mem_hold, 0);
    check("rst_en", m_en, 0);
    check("rst_we", m_we, 0);
    check("rst_addr", m_addr, 0);
    check("rst_din", m_din, 0);
    next_cycle();
    Rst = 0;
    idle_inputs();
    @(negedge clk);
    check("post_rst_cnt", conflict_cnt, 0);
    check("post_rst_en", m_en, 0);
    next_cycle();

    for (int w = 0; w < 512; w++) prog_write(w, gmem[w]);
    prog_write(4, 32'h0050_0093);
    prog_write(32'h100, 32'hDEAD_BEEF);
    prog_write(2, 32'h0000_0013);
    prog_write(32'h10, 32'h1122_3344);

    run_txn(1, 0, 4, 0, 4'h0, 0);
    run_txn(1, 1, 2, 32'h100, 4'h0, 0);
    run_txn(1, 2, 3, 32'h10, 4'b0011, 32'hAABB_CCDD);
    check("store_merge", bram[16], 32'h1122_CCDD);

    prog_write(0, 1);
    prog_write(1, 2);
    prog_write(2, 3);
    check("prog_w0", bram[0], 1);
    check("prog_w1", bram[1], 2);
    check("prog_w2", bram[2], 3);
    run_txn(1, 0, 1, 0, 4'h0, 0);

    // Programmer takes over mid-conflict: fetch dropped, no buffered data shown.
    idle_inputs();
    i_en = 1; i_addr = rand_addr(5); d_rea = 1; d_en = 4'hF; d_addr = rand_addr(6);
    exp_cnt = sat_inc(exp_cnt);
    @(negedge clk);
    check("ps_hold0", mem_hold, 1);
    next_cycle();
    prog_ena = 1; prog_we = 0; prog_addr = rand_addr(7);
    @(negedge clk);
    check("ps_hold1", mem_hold, 1);
    check("ps_addr", m_addr, 7);
    check("ps_we", m_we, 0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("ps_hold2", mem_hold, 0);
    check("ps_en", m_en, 0);
    check("ps_d_dout", d_dout, gmem[7]);
    check("ps_cnt", conflict_cnt, exp_cnt);
    next_cycle();

    // Reset mid-conflict: next cycle is plain IDLE.
    i_en = 1; i_addr = rand_addr(9); d_rea = 1; d_en = 4'hF; d_addr = rand_addr(8);
    @(negedge clk);
    check("rs_hold0", mem_hold, 1);
    next_cycle();
    Rst = 1;
    @(negedge clk);
    check("rs_en", m_en, 0);
    check("rs_hold", mem_hold, 0);
    next_cycle();
    Rst = 0;
    exp_cnt = 0;
    idle_inputs();
    d_rea = 1; d_en = 4'hF; d_addr = rand_addr(10); i_addr = rand_addr(11);
    @(negedge clk);
    check("rs_idle_hold", mem_hold, 0);
    check("rs_idle_addr", m_addr, 10);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rs_d_dout", d_dout, gmem[10]);
    check("rs_cnt", conflict_cnt, 0);
    next_cycle();

    for (int n = 0; n < CNTMAX + 3; n++) run_txn(1, 1, n, n + 40, 4'h0, 0);
    check("sat_cnt", conflict_cnt, CNTMAX);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) prog_write($urandom_range(0, 31), $urandom());
      else run_txn($urandom_range(0, 1), int'($urandom_range(0, 2)), $urandom_range(0, 31),
                   $urandom_range(0, 31), 4'($urandom_range(1, 15)), $urandom());
    end
    check("final_cnt", conflict_cnt, CNTMAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/umem_arbiter.md
Name: umem_arbiter

Overview:
- Single-port arbiter/sequencer in front of the unified BRAM shared by instruction fetch, data memory stage and the UART programmer.
- Serialises same-cycle fetch and load/store conflicts by raising mem_hold for one cycle, and buffers the early data response so the core sees both results on release.
- Gives the programmer exclusive ownership while prog_ena is high.
- Sits between the core's imem/mem ports and the BRAM. Its mem_hold drives the core's mem_hold input.

Parameters:
ADDR_W, 12, BRAM word-address width (m_addr = byte_addr[ADDR_W+1:2])
DATA_W, 32, data word width
CNT_W, 32, width of saturating conflict counter

Ports:
clk  in  1  system clock
Rst  in  1  synchronous active-high reset
prog_ena  in  1  programmer owns memory
prog_we  in  1  programmer write strobe
prog_addr  in  32  programmer byte address
prog_din  in  DATA_W  programmer write data
i_en  in  1  fetch request
i_addr  in  32  fetch byte address
i_dout  out  DATA_W  fetch read data (cycle after acceptance)
d_en  in  4  data byte enables
d_wea  in  1  store request
d_rea  in  1  load request
d_addr  in  32  data byte address
d_din  in  DATA_W  store data
d_dout  out  DATA_W  load data (cycle after acceptance)
mem_hold  out  1  stall core pipeline this cycle
m_en  out  1  BRAM enable
m_we  out  4  BRAM byte write enables
m_addr  out  ADDR_W  BRAM word address
m_din  out  DATA_W  BRAM write data
m_dout  in  DATA_W  BRAM read data, valid 1 cycle after issue
conflict_cnt  out  CNT_W  number of conflict-stall cycles, saturating

Behaviour:
- d_req = d_wea | d_rea. While held, the core re-presents identical requests every cycle.
- BRAM latency is fixed at 1: a read issued in cycle T has m_dout valid in T+1.
- FSM states: IDLE, SPLIT, PROG. Registers: state, d_buf[DATA_W], use_dbuf, conflict_cnt.
- Reset (Rst high at a clk edge): state=IDLE, use_dbuf=0, d_buf=0, conflict_cnt=0.
  - While Rst is high: m_en=0, m_we=0, mem_hold=0, m_addr=0, m_din=0.
- IDLE:
  - prog_ena=1 -> PROG. The programmer port is driven to the BRAM in the same cycle. mem_hold=1.
  - d_req only: BRAM driven from the data port (m_we = d_wea ? d_en : 0). mem_hold=0.
  - i_en only: BRAM driven from fetch (m_we=0). mem_hold=0.
  - d_req and i_en: data issued this cycle, mem_hold=1, conflict_cnt+1 -> SPLIT.
  - Neither request: m_en=0.
- SPLIT (core still presenting both requests):
  - Fetch is issued (m_en=1, m_we=0). mem_hold=0, which releases the core.
  - At the edge: d_buf<=m_dout (the data load result), use_dbuf<=1 -> IDLE.
  - The data request is not re-issued, so a store is never written twice.
- use_dbuf is a one-cycle flag, cleared at every edge not leaving SPLIT.
- d_dout = use_dbuf ? d_buf : m_dout. i_dout = m_dout always.
- Net cost of a conflict: exactly one hold cycle. Both results are visible in the cycle after release.
- PROG:
  - m_en=1, m_we = prog_we ? 4'hF : 0, m_addr/m_din from the prog port.
  - mem_hold=1, i_dout=m_dout (lets the debug view read imem).
  - prog_ena=0 -> IDLE with mem_hold=0 that same cycle. The request is arbitrated per IDLE rules.
- prog_ena has priority in every state. If it is asserted during SPLIT, the fetch is not issued, use_dbuf<=0 and the state goes to PROG.
- Rst mid-SPLIT aborts the conflict: no buffered data is presented, and the next cycle is IDLE.
- conflict_cnt saturates at all-ones and never wraps.
- Address bits [1:0] and bits above ADDR_W+1 are ignored.

Decomposition:
- Shared package umem_pkg:
  - typedef enum logic[1:0] {ARB_IDLE, ARB_SPLIT, ARB_PROG} arb_state_t
  - typedef struct mem_req_t {en, we[3:0], addr, din}
  - BRAM latency constant MEM_LAT=1
- One natural sub-module, umem_req_mux: purely combinational selection of mem_req_t from prog/data/fetch by a select code.
- The FSM, d_buf and the counter stay in umem_arbiter.

Test Plan:
- Fetch only, i_addr=0x10, BRAM[4]=0x00500093 -> m_addr=4, mem_hold=0; next cycle i_dout=0x00500093.
- Load+fetch same cycle, d_addr=0x400 (BRAM[0x100]=0xDEADBEEF), i_addr=0x8 (BRAM[2]=0x13) -> cycle T m_addr=0x100, hold=1; T+1 m_addr=2, hold=0; T+2 d_dout=0xDEADBEEF, i_dout=0x13, conflict_cnt=1.
- Store+fetch, d_en=4'b0011, d_din=0xAABBCCDD at 0x40 (old 0x11223344) -> exactly one write pulse with m_we=0011; BRAM[0x10]=0x1122CCDD; one hold cycle.
- prog_ena raised for 3 writes to words 0,1,2 with values 1,2,3 -> mem_hold=1 throughout and BRAM holds 1,2,3. After prog_ena drops, mem_hold=0 the same cycle.
- prog_ena asserted during SPLIT -> fetch not issued, use_dbuf=0, state PROG; Rst during SPLIT -> next cycle IDLE, m_en=0, use_dbuf=0.
- Force conflict_cnt to all-ones minus 1, then 3 conflicts -> counter saturates at all-ones and does not wrap.
